// File: rtl/qea_host_sequencer.sv
// rtl/qea_host_sequencer.sv - host run sequencer: context load, state init, core start/run, state readback
module qea_host_sequencer #(
    parameter int PE_NUM           = 4,
    parameter int PE_NUM_WIDTH     = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int CTX_ADDR_WIDTH   = 16,
    parameter int CTX_DATA_WIDTH   = 64,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int CYC_WIDTH        = 32,
    parameter int RD_LATENCY       = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
    input  logic [CTX_ADDR_WIDTH-1:0]                i_ins_num,
    input  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] i_init_index,
    input  logic [CYC_WIDTH-1:0]                     i_timeout,
    input  logic                                     i_ctx_valid,
    output logic                                     o_ctx_ready,
    input  logic [CTX_DATA_WIDTH-1:0]                i_ctx_data,
    output logic                                     o_ctx_en,
    output logic                                     o_ctx_wea,
    output logic [CTX_ADDR_WIDTH-1:0]                o_ctx_addr,
    output logic [CTX_DATA_WIDTH-1:0]                o_ctx_data,
    output logic [PE_NUM-1:0]                        o_state_ena,
    output logic [PE_NUM-1:0]                        o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]           o_state_dina,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]           i_state_dout,
    output logic                                     o_start,
    input  logic                                     i_complete,
    output logic                                     o_rd_valid,
    input  logic                                     i_rd_ready,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]           o_rd_data,
    output logic                                     o_rd_last,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_timeout_err,
    output logic                                     o_cfg_err,
    output logic [CYC_WIDTH-1:0]                     o_cycles
);
    localparam int SW = 2 * DATA_WIDTH;
    localparam int LW = PE_NUM * SW;
    localparam int IW = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam logic [SW-1:0] AMP_ONE = SW'(1) << (NUM_FRAC_BIT + DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_CTX, S_INIT, S_START, S_RUN, S_READ, S_DONE} state_t;
    typedef enum logic [1:0] {RD_ISSUE, RD_WAIT, RD_HOLD} rd_phase_t;

    state_t                    state_q, state_d;
    rd_phase_t                 rd_phase_q, rd_phase_d;
    logic [CTX_ADDR_WIDTH-1:0] ins_num_q, ins_num_d, ctx_cnt_q, ctx_cnt_d;
    logic [IW-1:0]             init_index_q, init_index_d;
    logic [CYC_WIDTH-1:0]      timeout_q, timeout_d, cycles_q, cycles_d, cycles_inc;
    logic [STATE_ADDR_WIDTH-1:0] last_row_q, last_row_d, row_q, row_d;
    logic [7:0]                lat_q, lat_d;
    logic                      ctx_ready_q, ctx_ready_d, ctx_en_q, ctx_en_d, ctx_wea_q, ctx_wea_d;
    logic [CTX_ADDR_WIDTH-1:0] ctx_addr_q, ctx_addr_d;
    logic [CTX_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
    logic [PE_NUM-1:0]         state_ena_q, state_ena_d, state_wea_q, state_wea_d;
    logic [STATE_ADDR_WIDTH-1:0] state_addra_q, state_addra_d;
    logic [LW-1:0]             state_dina_q, state_dina_d, rd_data_q, rd_data_d;
    logic                      start_q, start_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic                      busy_q, busy_d, done_q, done_d, timeout_err_q, timeout_err_d;
    logic                      cfg_err_q, cfg_err_d;

    logic                      cfg_bad;
    logic [STATE_ADDR_WIDTH:0] rows_go;
    logic [STATE_ADDR_WIDTH-1:0] last_row_go, init_row;
    logic [LW-1:0]             amp_top, init_word;

    // Index out of range is detected by any bit surviving the shift by qbit_num.
    assign cfg_bad = (i_ins_num == '0)
                  || (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
                  || (i_qbit_num > MAX_QBIT_WIDTH'(PE_NUM_WIDTH + STATE_ADDR_WIDTH))
                  || ((i_init_index >> i_qbit_num) != '0);
    assign rows_go     = (STATE_ADDR_WIDTH+1)'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
    assign last_row_go = STATE_ADDR_WIDTH'(rows_go - (STATE_ADDR_WIDTH+1)'(1));
    assign init_row    = init_index_q[IW-1:PE_NUM_WIDTH];
    assign amp_top     = LW'(AMP_ONE) << (LW - SW);
    assign init_word   = amp_top >> (SW * int'(init_index_q[PE_NUM_WIDTH-1:0]));
    assign cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + CYC_WIDTH'(1);

    always_comb begin
        state_d       = state_q;       rd_phase_d    = rd_phase_q;
        ins_num_d     = ins_num_q;     ctx_cnt_d     = ctx_cnt_q;
        init_index_d  = init_index_q;  timeout_d     = timeout_q;
        cycles_d      = cycles_q;      last_row_d    = last_row_q;
        row_d         = row_q;         lat_d         = lat_q;
        ctx_ready_d   = ctx_ready_q;   ctx_addr_d    = ctx_addr_q;
        ctx_data_d    = ctx_data_q;    state_addra_d = state_addra_q;
        state_dina_d  = state_dina_q;  rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;    rd_last_d     = rd_last_q;
        timeout_err_d = timeout_err_q;
        ctx_en_d      = 1'b0;          ctx_wea_d     = 1'b0;
        state_ena_d   = '0;            state_wea_d   = '0;
        start_d       = 1'b0;          done_d        = 1'b0;
        cfg_err_d     = 1'b0;
        case (state_q)
            S_IDLE: if (i_go) begin
                if (cfg_bad) begin
                    cfg_err_d = 1'b1;
                end else begin
                    ins_num_d     = i_ins_num;
                    init_index_d  = i_init_index;
                    timeout_d     = i_timeout;
                    last_row_d    = last_row_go;
                    ctx_cnt_d     = '0;
                    cycles_d      = '0;
                    timeout_err_d = 1'b0;
                    ctx_ready_d   = 1'b1;
                    state_d       = S_LOAD_CTX;
                end
            end
            S_LOAD_CTX: if (i_ctx_valid && ctx_ready_q) begin
                ctx_en_d   = 1'b1;
                ctx_wea_d  = 1'b1;
                ctx_addr_d = ctx_cnt_q;
                ctx_data_d = i_ctx_data;
                ctx_cnt_d  = ctx_cnt_q + CTX_ADDR_WIDTH'(1);
                if (ctx_cnt_q == ins_num_q - CTX_ADDR_WIDTH'(1)) begin
                    ctx_ready_d = 1'b0;
                    row_d       = '0;
                    state_d     = S_INIT;
                end
            end
            S_INIT: begin
                state_ena_d   = '1;
                state_wea_d   = '1;
                state_addra_d = row_q;
                state_dina_d  = (row_q == init_row) ? init_word : '0;
                if (row_q == last_row_q) state_d = S_START;
                else                     row_d   = row_q + STATE_ADDR_WIDTH'(1);
            end
            S_START: begin
                start_d  = 1'b1;
                cycles_d = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (i_complete) begin
                    cycles_d   = cycles_inc;
                    row_d      = '0;
                    rd_phase_d = RD_ISSUE;
                    state_d    = S_READ;
                end else if ((timeout_q != '0) && (cycles_q == timeout_q)) begin
                    timeout_err_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cycles_d = cycles_inc;
                end
            end
            S_READ: begin
                case (rd_phase_q)
                    RD_ISSUE: begin
                        state_ena_d   = '1;
                        state_addra_d = row_q;
                        lat_d         = 8'(RD_LATENCY);
                        rd_phase_d    = RD_WAIT;
                    end
                    // lat_q counts down from the cycle the enable is on the RAM port.
                    RD_WAIT: begin
                        if (lat_q == '0) begin
                            rd_data_d  = i_state_dout;
                            rd_valid_d = 1'b1;
                            rd_last_d  = (row_q == last_row_q);
                            rd_phase_d = RD_HOLD;
                        end else begin
                            lat_d = lat_q - 8'd1;
                        end
                    end
                    RD_HOLD: if (i_rd_ready) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        if (row_q == last_row_q) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            row_d      = row_q + STATE_ADDR_WIDTH'(1);
                            rd_phase_d = RD_ISSUE;
                        end
                    end
                    default: rd_phase_d = RD_ISSUE;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;      rd_phase_q <= RD_ISSUE;
            ins_num_q <= '0;        ctx_cnt_q <= '0;
            init_index_q <= '0;     timeout_q <= '0;
            cycles_q <= '0;         last_row_q <= '0;
            row_q <= '0;            lat_q <= '0;
            ctx_ready_q <= 1'b0;    ctx_en_q <= 1'b0;      ctx_wea_q <= 1'b0;
            ctx_addr_q <= '0;       ctx_data_q <= '0;
            state_ena_q <= '0;      state_wea_q <= '0;
            state_addra_q <= '0;    state_dina_q <= '0;
            start_q <= 1'b0;        rd_valid_q <= 1'b0;    rd_last_q <= 1'b0;
            rd_data_q <= '0;        busy_q <= 1'b0;        done_q <= 1'b0;
            timeout_err_q <= 1'b0;  cfg_err_q <= 1'b0;
        end else begin
            state_q <= state_d;     rd_phase_q <= rd_phase_d;
            ins_num_q <= ins_num_d; ctx_cnt_q <= ctx_cnt_d;
            init_index_q <= init_index_d; timeout_q <= timeout_d;
            cycles_q <= cycles_d;   last_row_q <= last_row_d;
            row_q <= row_d;         lat_q <= lat_d;
            ctx_ready_q <= ctx_ready_d; ctx_en_q <= ctx_en_d; ctx_wea_q <= ctx_wea_d;
            ctx_addr_q <= ctx_addr_d;   ctx_data_q <= ctx_data_d;
            state_ena_q <= state_ena_d; state_wea_q <= state_wea_d;
            state_addra_q <= state_addra_d; state_dina_q <= state_dina_d;
            start_q <= start_d;     rd_valid_q <= rd_valid_d; rd_last_q <= rd_last_d;
            rd_data_q <= rd_data_d; busy_q <= busy_d;      done_q <= done_d;
            timeout_err_q <= timeout_err_d; cfg_err_q <= cfg_err_d;
        end
    end

    assign o_ctx_ready   = ctx_ready_q;
    assign o_ctx_en      = ctx_en_q;
    assign o_ctx_wea     = ctx_wea_q;
    assign o_ctx_addr    = ctx_addr_q;
    assign o_ctx_data    = ctx_data_q;
    assign o_state_ena   = state_ena_q;
    assign o_state_wea   = state_wea_q;
    assign o_state_addra = state_addra_q;
    assign o_state_dina  = state_dina_q;
    assign o_start       = start_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = rd_data_q;
    assign o_rd_last     = rd_last_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_timeout_err = timeout_err_q;
    assign o_cfg_err     = cfg_err_q;
    assign o_cycles      = cycles_q;
endmodule

// File: doc/qea_host_sequencer.md
QEA_HOST_SEQUENCER -- requirements
Module: qea_host_sequencer

Interface
REQ-001 SHALL have parameter PE_NUM, default 4, number of amplitude lanes per state-RAM word.
REQ-002 SHALL have parameter PE_NUM_WIDTH, default 2, log2(PE_NUM).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of the real or imaginary part; amplitude width SW = 2*DATA_WIDTH.
REQ-004 SHALL have parameters STATE_ADDR_WIDTH=16, CTX_ADDR_WIDTH=16, CTX_DATA_WIDTH=64, MAX_QBIT_WIDTH=6, NUM_FRAC_BIT=30, CYC_WIDTH=32, RD_LATENCY=1 (state-RAM read latency, in cycles).
REQ-005 SHALL have one clock and a synchronous active-high reset; all other ports are listed below.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 i_go  in  1  starts a run when the block is idle.
REQ-009 i_qbit_num  in  MAX_QBIT_WIDTH  qubit count; latched on accepted i_go.
REQ-010 i_ins_num  in  CTX_ADDR_WIDTH  number of context words; latched.
REQ-011 i_init_index  in  STATE_ADDR_WIDTH+PE_NUM_WIDTH  initial basis-state index; latched.
REQ-012 i_timeout  in  CYC_WIDTH  run-cycle limit; 0 = no limit; latched.
REQ-013 i_ctx_valid / o_ctx_ready  in / out  1  context-word input handshake.
REQ-014 i_ctx_data  in  CTX_DATA_WIDTH  context word.
REQ-015 o_ctx_en, o_ctx_wea  out  1  context-RAM write strobes.
REQ-016 o_ctx_addr  out  CTX_ADDR_WIDTH; o_ctx_data  out  CTX_DATA_WIDTH.
REQ-017 o_state_ena, o_state_wea  out  PE_NUM  per-lane state-RAM enable and write enable.
REQ-018 o_state_addra  out  STATE_ADDR_WIDTH; o_state_dina  out  PE_NUM*SW.
REQ-019 i_state_dout  in  PE_NUM*SW  state-RAM read data.
REQ-020 o_start  out  1  one-cycle core start pulse; i_complete  in  1  core completion level.
REQ-021 o_rd_valid / i_rd_ready  out / in  1  readback handshake; o_rd_data  out  PE_NUM*SW; o_rd_last  out  1.
REQ-022 o_busy, o_done, o_timeout_err, o_cfg_err  out  1 each; o_cycles  out  CYC_WIDTH.

Function
REQ-023 SHALL use FSM states IDLE -> LOAD_CTX -> INIT -> START -> RUN -> READ -> DONE -> IDLE.
REQ-024 IDLE: on i_go, SHALL latch the configuration; i_go in any other state SHALL be ignored.
REQ-025 Configuration SHALL be rejected, o_cfg_err pulsed for 1 cycle, and the FSM SHALL stay in IDLE if any of these hold: i_ins_num==0; qbit_num<PE_NUM_WIDTH; qbit_num>PE_NUM_WIDTH+STATE_ADDR_WIDTH; init_index>=2^qbit_num.
REQ-026 LOAD_CTX: o_ctx_ready=1; each valid&ready transfer SHALL drive o_ctx_en=o_ctx_wea=1 on the next cycle with addresses 0,1,2,... and no gaps beyond valid stalls; after ins_num words the FSM SHALL go to INIT.
REQ-027 INIT: SHALL write rows 0..R-1 (R=2^(qbit_num-PE_NUM_WIDTH)), one row per cycle, with o_state_ena=o_state_wea=all-ones.
REQ-028 Basis index i SHALL map to row i>>PE_NUM_WIDTH and lane k=i mod PE_NUM at bits [(PE_NUM-k)*SW-1 -: SW]; the real part SHALL occupy the upper DATA_WIDTH bits of the lane.
REQ-029 The init_index amplitude SHALL be real = 1<<NUM_FRAC_BIT, imaginary 0; all other amplitudes SHALL be 0.
REQ-030 START: o_start=1 for exactly one cycle; o_cycles SHALL clear to 0 in the same cycle.
REQ-031 RUN: o_cycles SHALL increment every cycle, saturating at all-ones; on i_complete=1 the FSM SHALL go to READ.
REQ-032 If timeout!=0 and o_cycles==timeout with i_complete=0, SHALL set o_timeout_err and go to DONE, skipping READ; i_complete takes priority when both occur in the same cycle.
REQ-033 READ: for each row SHALL issue one read (ena=all-ones, wea=0), capture i_state_dout RD_LATENCY cycles later into o_rd_data, and assert o_rd_valid.
REQ-034 Readback data SHALL hold stable until i_rd_ready; the next read SHALL be issued only after the transfer; o_rd_last=1 on row R-1.
REQ-035 DONE: o_done=1 for one cycle, then IDLE; o_busy=1 in every state except IDLE.
REQ-036 o_cycles and o_timeout_err SHALL hold until the next accepted i_go clears them.

Reset
REQ-037 rst=1 SHALL force IDLE and drive every output to 0 (including o_ctx_ready, o_rd_valid, o_cycles, and all strobes) on the next edge, abandoning any operation in progress.

Verification
REQ-038 PE_NUM=4, qbit=13, ins_num=181, init_index=0, stub core completes 100 cycles after start -> 181 ctx writes at addresses 0..180, 2048 init rows, row 0 = 40000000_00000000 in the MSB lane, o_cycles=101, 2048 readbacks with o_rd_last on the final one, o_done pulse.
REQ-039 init_index=5, qbit=4 -> 4 init rows; only row 1, lane 1 nonzero.
REQ-040 qbit=1, or ins_num=0, or init_index=16 with qbit=4 -> o_cfg_err pulse, no RAM strobes, o_busy stays 0.
REQ-041 timeout=50, core never completes -> o_timeout_err=1, o_cycles=50, no o_rd_valid, o_done pulse.
REQ-042 random i_ctx_valid gaps and i_rd_ready backpressure -> no lost or duplicated words, o_rd_data stable while stalled.
REQ-043 rst asserted mid-INIT -> all outputs 0 on the next cycle; a following i_go runs to completion normally.
